// File: rtl/pwm_decoder.sv
// PWM receiver: synchronises pwm_in, samples it on enable ticks and recovers
// the duty value from the high time of each 2^WIDTH-tick frame.
module pwm_decoder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             enable,
   input  logic             pwm_in,
   output logic [WIDTH-1:0] value,
   output logic             valid,
   output logic             locked,
   output logic             error
);

   typedef enum logic {IDLE, MEASURE} state_t;

   localparam logic [WIDTH:0] FRAME = {1'b1, {WIDTH{1'b0}}};
   localparam logic [WIDTH:0] ONE   = {{WIDTH{1'b0}}, 1'b1};

   logic             sync1_q, sync1_d;
   logic             s_q, s_d;
   logic             prev_q, prev_d;
   logic [WIDTH:0]   period_cnt_q, period_cnt_d;
   logic [WIDTH:0]   high_cnt_q, high_cnt_d;
   state_t           state_q, state_d;
   logic [WIDTH-1:0] value_q, value_d;
   logic             valid_q, valid_d;
   logic             locked_q, locked_d;
   logic             error_q, error_d;
   logic             rise;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q      <= 1'b0;
         s_q          <= 1'b0;
         prev_q       <= 1'b0;
         period_cnt_q <= '0;
         high_cnt_q   <= '0;
         state_q      <= IDLE;
         value_q      <= '0;
         valid_q      <= 1'b0;
         locked_q     <= 1'b0;
         error_q      <= 1'b0;
      end else begin
         sync1_q      <= sync1_d;
         s_q          <= s_d;
         prev_q       <= prev_d;
         period_cnt_q <= period_cnt_d;
         high_cnt_q   <= high_cnt_d;
         state_q      <= state_d;
         value_q      <= value_d;
         valid_q      <= valid_d;
         locked_q     <= locked_d;
         error_q      <= error_d;
      end
   end

   always_comb begin
      sync1_d      = pwm_in;
      s_d          = sync1_q;
      prev_d       = prev_q;
      period_cnt_d = period_cnt_q;
      high_cnt_d   = high_cnt_q;
      state_d      = state_q;
      value_d      = value_q;
      valid_d      = 1'b0;
      locked_d     = locked_q;
      error_d      = 1'b0;
      rise         = s_q & ~prev_q;

      if (enable) begin
         prev_d = s_q;
         if (rise) begin
            // The first rise after IDLE only sets the reference point.
            period_cnt_d = ONE;
            high_cnt_d   = ONE;
            state_d      = MEASURE;
            if (state_q == MEASURE) begin
               if (period_cnt_q == FRAME) begin
                  value_d  = high_cnt_q[WIDTH-1:0];
                  valid_d  = 1'b1;
                  locked_d = 1'b1;
               end else begin
                  error_d  = 1'b1;
                  locked_d = 1'b0;
               end
            end
         end else if (period_cnt_q == FRAME) begin
            // A whole frame without a rise: the line is stuck at s_q.
            state_d      = IDLE;
            period_cnt_d = ONE;
            high_cnt_d   = {{WIDTH{1'b0}}, s_q};
            if (s_q) begin
               value_d  = '1;
               error_d  = 1'b1;
               locked_d = 1'b0;
            end else begin
               value_d  = '0;
               valid_d  = 1'b1;
               locked_d = 1'b1;
            end
         end else begin
            period_cnt_d = period_cnt_q + ONE;
            high_cnt_d   = high_cnt_q + {{WIDTH{1'b0}}, s_q};
         end
      end
   end

   assign value  = value_q;
   assign valid  = valid_q;
   assign locked = locked_q;
   assign error  = error_q;

endmodule

// File: tb/tb_pwm_decoder.sv
// Randomised bench for pwm_decoder: a tick-level transmitter drives the line and a
// frame-level reference model (rise positions and sample counts) predicts every output.
module tb_pwm_decoder;
   localparam int W = 8;
   localparam int P = 256;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         enable = 1'b0;
   logic         pwm_in = 1'b0;
   logic [W-1:0] value;
   logic         valid;
   logic         locked;
   logic         error;

   always #5 clk = ~clk;

   pwm_decoder #(.WIDTH(W)) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .enable (enable),
      .pwm_in (pwm_in),
      .value  (value),
      .valid  (valid),
      .locked (locked),
      .error  (error)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %0d want %0d", tag, $time, obs, exp);
      end
   endtask

   // Reference model: per-tick sample history, the tick where the current
   // frame was anchored, and whether that anchor was a real rising edge.
   bit sarr [0:19999];
   int t;
   int start;
   bit meas;
   bit m_prev;
   int m_value;
   bit m_locked;
   bit e_valid, e_err;
   bit pipe1, pipe2;
   int div = 1;

   task automatic model_reset();
      t = 0; start = 1; meas = 0; m_prev = 0;
      m_value = 0; m_locked = 0; pipe1 = 0; pipe2 = 0;
   endtask

   task automatic model_tick(input bit s);
      int hc;
      bit rise;
      t++;
      sarr[t] = s;
      rise = s && !m_prev;
      m_prev = s;
      if (rise) begin
         if (meas && (t - start) == P) begin
            hc = 0;
            for (int i = start; i < t; i++) hc += int'(sarr[i]);
            m_value = hc; e_valid = 1; m_locked = 1;
         end else if (meas) begin
            e_err = 1; m_locked = 0;
         end
         start = t; meas = 1;
      end else if ((t - start) == P) begin
         if (s) begin
            m_value = P - 1; e_err = 1; m_locked = 0;
         end else begin
            m_value = 0; e_valid = 1; m_locked = 1;
         end
         start = t; meas = 0;
      end
   endtask

   // Called at a negedge; returns at the following negedge.
   task automatic step(input bit en, input bit p);
      bit s_use;
      enable = en;
      pwm_in = p;
      s_use = pipe2;
      pipe2 = pipe1;
      pipe1 = p;
      e_valid = 0;
      e_err = 0;
      if (en) model_tick(s_use);
      @(posedge clk);
      #1;
      check("valid", valid, e_valid);
      check("error", error, e_err);
      check("value", value, m_value);
      check("locked", locked, m_locked);
      check("excl", valid & error, 0);
      if (e_valid || e_err)
         $display("t=%0t tick=%0d %s value=%0d locked=%0d", $time, t,
                  e_valid ? "valid" : "error", m_value, m_locked);
      @(negedge clk);
   endtask

   task automatic tick_out(input bit p);
      step(1'b1, p);
      for (int i = 1; i < div; i++) step(1'b0, p);
   endtask

   task automatic frame(input int v, input int len);
      for (int i = 0; i < len; i++) tick_out(i < v);
   endtask

   task automatic hold(input bit p, input int n);
      for (int i = 0; i < n; i++) tick_out(p);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      enable = 1'b0;
      #1;
      check("rst_value", value, 0);
      check("rst_valid", valid, 0);
      check("rst_locked", locked, 0);
      check("rst_error", error, 0);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      model_reset();
   endtask

   initial begin
      int len, v;
      model_reset();
      @(negedge clk);
      do_reset();

      div = 1;
      repeat (4) frame(100, P);
      check("v100", value, 100);
      check("lock100", locked, 1);

      div = 4;
      frame(1, P); frame(1, P);
      frame(128, P); frame(128, P);
      frame(255, P); frame(255, P);
      tick_out(1'b1); tick_out(1'b1);
      check("v255", value, 255);

      hold(1'b1, 300);
      check("stuck_hi_val", value, 255);
      check("stuck_hi_lock", locked, 0);
      hold(1'b0, 600);

      div = 2;
      repeat (3) frame(100, P);
      frame(100, 200);
      repeat (3) frame(100, P);

      repeat (15) begin
         div = $urandom_range(1, 4);
         case ($urandom_range(0, 5))
            0:       len = 200;
            1:       len = 270;
            default: len = P;
         endcase
         v = $urandom_range(1, (len < P) ? len - 1 : P - 1);
         frame(v, len);
      end

      div = 1;
      repeat (3) frame(100, P);
      frame(100, 50);
      do_reset();
      repeat (3) frame(60, P);
      tick_out(1'b1); tick_out(1'b1); tick_out(1'b1);
      check("v60", value, 60);

      do_reset();
      hold(1'b0, 600);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/pwm_decoder.md
# pwm_decoder

Recovers the duty value from a PWM waveform like the one the candle-flicker PWM stage produces: an 8-bit value `v` drives the line high for `v` ticks out of a 2^WIDTH-tick frame. The block synchronises an external PWM input, samples it on an enable strobe from the existing `counter` divider, and measures high time and frame length between rising edges. Each valid measurement is reported as a value with a one-cycle strobe. It is the receive end of the flicker PWM link, used for loop-back self-test and for driving slave candles from a master.

## Interface
- WIDTH, 8, duty resolution in bits; frame length P = 2^WIDTH ticks.
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  sample tick, one clk wide, from a `counter` divider set to the transmitter's PWM tick rate.
- pwm_in  in  1  asynchronous PWM line.
- value  out  WIDTH  last decoded duty; holds between updates.
- valid  out  1  one-clk pulse when `value` is updated.
- locked  out  1  high while frames of exactly P ticks are being received.
- error  out  1  one-clk pulse on a bad frame length or a stuck-high line.

## Operation
- Synchroniser: two flops on `pwm_in`, both reset to 0. The second stage is `s`.
- All measurement logic advances only on clocks where `enable`=1. When `enable`=0 the counters and `prev` hold, and `valid`/`error` are 0.
- Registers:
  - `prev`: the `s` sample from the previous tick, reset 0.
  - `period_cnt` and `high_cnt`: each WIDTH+1 bits, reset 0.
  - `state`: IDLE or MEASURE, reset IDLE.
- On each tick, rise = s & ~prev; then prev <= s.
- Rise in IDLE: state <= MEASURE; period_cnt <= 1; high_cnt <= 1; no output.
- Rise in MEASURE, good frame (period_cnt == P): value <= high_cnt[WIDTH-1:0]; valid pulse; locked <= 1; period_cnt <= 1; high_cnt <= 1; stay in MEASURE.
- Rise in MEASURE, bad frame (period_cnt != P): error pulse; locked <= 0; value unchanged; period_cnt <= 1; high_cnt <= 1; stay in MEASURE.
- No rise and period_cnt < P: period_cnt += 1; high_cnt += s.
- Timeout: no rise and period_cnt == P, meaning a full frame with no rising edge. This applies in either state.
  - If s=0 (line stuck low): value <= 0; valid pulse; locked <= 1.
  - If s=1 (line stuck high, which the transmitter cannot produce): value <= 2^WIDTH-1; error pulse; locked <= 0.
  - In both cases: state <= IDLE; period_cnt <= 1; high_cnt <= s.
- Width rules:
  - Counters never exceed P, because timeout fires at P.
  - high_cnt ≤ period_cnt always.
  - On a good frame high_cnt ≤ P-1, so truncation to WIDTH bits is lossless.
- `valid` and `error` are never asserted together.

## Timing
- Reset values: value=0, valid=0, locked=0, error=0, state IDLE, counters 0.
- Input latency: an edge on `pwm_in` reaches `s` 2 clks later and is acted on at the first `enable` tick after that.
- Output latency: `value`, `valid`, `locked` and `error` are registered and change on the clk edge of the deciding enable tick.
- First result after reset:
  - Needs two rising edges: the first is the IDLE reference, the second closes the first frame.
  - With a stuck-low line, the first timeout fires on tick P+1 after reset (counting starts from 0). Later timeouts fire every P ticks.
- Reset asserted mid-frame: all outputs and state return to reset values immediately; the partial frame is discarded.
- A glitch shorter than 2 clks may be missed. A glitch spanning a tick counts as a real edge and typically gives a bad-frame `error`.

## Test plan
- Transmitter `v`=100, P=256, enable every clk, after reset: no `valid` on the first rise. At the second rise `value`=100, `valid` pulses once, `locked`=1. Every later frame re-pulses `valid` with 100.
- Sweep `v` over 1, 128 and 255 with enable every 4th clk: each reports the exact `v`. The `v`=255 frame has a single low tick and must still decode as 255.
- `pwm_in` held 0 after reset: `valid` with `value`=0, `locked`=1 on enable tick 257, then every 256 ticks. `error` never pulses.
- `pwm_in` held 1 while locked: `error` pulses 256 ticks after the last rise, `value`=255, `locked`=0, `valid` stays 0.
- Frame of 200 ticks injected between good 256-tick frames: `error` pulses at the short frame's closing rise, `locked`=0, `value` keeps its previous value. The next good frame restores `valid` and `locked`=1.
- `reset_n` pulsed low mid-frame while locked: all outputs 0 asynchronously. After release, the decoder needs two rises before `valid` pulses again.
